// File: rtl/prach_pkg.sv
// prach_pkg: shared sample type, widths and fixed-point helpers for the PRACH FFT stages.
package prach_pkg;
  localparam int DW = 18;
  localparam int TW_W = 18;
  localparam int TW_FRAC = 16;
  localparam int MW = DW + TW_W;
  localparam int PW = MW + 1;
  localparam int SMAX = (1 << (DW - 1)) - 1;
  localparam int SMIN = -(1 << (DW - 1));
  localparam real PI = 3.14159265358979323846;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  function automatic int idx_w(input int l);
    return (l > 1) ? l - 1 : 1;
  endfunction

  // (x+1)>>>1 of a 19-bit butterfly sum or difference
  function automatic logic signed [DW-1:0] bfly_half(input logic signed [DW:0] x);
    logic signed [DW:0] t;
    t = x + (DW+1)'(1);
    return t[DW:1];
  endfunction

  function automatic logic signed [DW-1:0] round_sat(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] t;
    t = (x + PW'(1 << (TW_FRAC - 1))) >>> TW_FRAC;
    return (t > PW'(SMAX)) ? DW'(SMAX) : (t < PW'(SMIN)) ? DW'(SMIN) : t[DW-1:0];
  endfunction

  function automatic logic signed [TW_W-1:0] tw_cos(input int n, input int d);
    return TW_W'(int'($cos(PI * n / d) * (1 << TW_FRAC)));
  endfunction

  function automatic logic signed [TW_W-1:0] tw_msin(input int n, input int d);
    return TW_W'(int'(-$sin(PI * n / d) * (1 << TW_FRAC)));
  endfunction
endpackage

// File: rtl/prach_diffft2_twiddler.sv
// prach_diffft2_twiddler: multiplies by W(n) = exp(-j*pi*n/D) over three register stages;
// byp selects W=1 so sums ride the same pipeline with matched delay.
module prach_diffft2_twiddler
  import prach_pkg::*;
#(
  parameter int NUM_FFT_LENGTH = 6
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  cplx_t                            din,
  input  logic [idx_w(NUM_FFT_LENGTH)-1:0] n,
  input  logic                             byp,
  input  logic [2:0]                       tag_in,
  output cplx_t                            dout,
  output logic [2:0]                       tag_out
);
  localparam int D = 1 << (NUM_FFT_LENGTH - 1);
  logic signed [TW_W-1:0] rom_re [D];
  logic signed [TW_W-1:0] rom_im [D];
  logic signed [TW_W-1:0] w_re, w_im;
  logic signed [MW-1:0] rr_d, ii_d, ri_d, ir_d, rr_q, ii_q, ri_q, ir_q;
  logic signed [PW-1:0] re_d, im_d, re_q, im_q;
  cplx_t dout_d, dout_q;
  logic [2:0] t1_d, t1_q, t2_d, t2_q, t3_d, t3_q;

  for (genvar i = 0; i < D; i++) begin : g_rom
    assign rom_re[i] = tw_cos(i, D);
    assign rom_im[i] = tw_msin(i, D);
  end

  always_comb begin
    w_re = byp ? TW_W'(1 << TW_FRAC) : rom_re[n];
    w_im = byp ? '0 : rom_im[n];
    rr_d = MW'(din.re) * MW'(w_re);
    ii_d = MW'(din.im) * MW'(w_im);
    ri_d = MW'(din.re) * MW'(w_im);
    ir_d = MW'(din.im) * MW'(w_re);
    re_d = PW'(rr_q) - PW'(ii_q);
    im_d = PW'(ri_q) + PW'(ir_q);
    dout_d = {round_sat(re_q), round_sat(im_q)};
    t1_d = tag_in;
    t2_d = t1_q;
    t3_d = t2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {rr_q, ii_q, ri_q, ir_q} <= '0;
      {re_q, im_q} <= '0;
      dout_q <= '0;
      {t1_q, t2_q, t3_q} <= '0;
    end else begin
      {rr_q, ii_q, ri_q, ir_q} <= {rr_d, ii_d, ri_d, ir_d};
      {re_q, im_q} <= {re_d, im_d};
      dout_q <= dout_d;
      {t1_q, t2_q, t3_q} <= {t1_d, t2_d, t3_d};
    end
  end

  assign dout = dout_q;
  assign tag_out = t3_q;
endmodule

// File: rtl/prach_diffft2.sv
// prach_diffft2: radix-2 DIF single-path delay-feedback stage. Upper-half samples meet the
// stored lower half; sums leave at once, differences wait in the feedback memory for twiddling.
module prach_diffft2
  import prach_pkg::*;
#(
  parameter int NUM_FFT_LENGTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] din_dr,
  input  logic signed [DW-1:0] din_di,
  input  logic                 din_dv,
  input  logic                 sync_in,
  input  logic                 sync_ahead_in,
  output logic signed [DW-1:0] dout_dr,
  output logic signed [DW-1:0] dout_di,
  output logic                 dout_dv,
  output logic                 sync_out,
  output logic                 sync_ahead_out
);
  localparam int D = 1 << (NUM_FFT_LENGTH - 1);
  localparam int KW = NUM_FFT_LENGTH;
  localparam int NW = idx_w(NUM_FFT_LENGTH);
  logic [KW-1:0] k_q, k_d, k_cur;
  logic primed_q, primed_d, resync, upper, vld;
  logic [NW-1:0] idx, n_q, n_d;
  logic byp_q, byp_d;
  logic [2:0] tag_q, tag_d, tag_o;
  cplx_t fifo_q [D];
  cplx_t fifo_d, head, sum, dif, bf_q, bf_d, tw_o;
  logic unused_sync_ahead;

  assign unused_sync_ahead = sync_ahead_in;

  always_comb begin
    resync = din_dv & sync_in;
    k_cur = resync ? '0 : k_q;
    upper = k_cur >= KW'(D);
    idx = NW'(k_cur) & NW'(D - 1);
    head = fifo_q[idx];
    sum.re = bfly_half((DW+1)'(head.re) + (DW+1)'(din_dr));
    sum.im = bfly_half((DW+1)'(head.im) + (DW+1)'(din_di));
    dif.re = bfly_half((DW+1)'(head.re) - (DW+1)'(din_dr));
    dif.im = bfly_half((DW+1)'(head.im) - (DW+1)'(din_di));
    fifo_d = upper ? dif : cplx_t'({din_dr, din_di});
    // a resync away from k=0 invalidates whatever the memory holds
    primed_d = din_dv ? (primed_q & ~(resync & |k_q)) | (k_cur == KW'(D)) : primed_q;
    vld = din_dv & primed_d;
    k_d = din_dv ? k_cur + 1'b1 : k_q;
    bf_d = upper ? sum : head;
    n_d = idx;
    byp_d = upper;
    tag_d = {vld, vld & (k_cur == KW'(D)), vld & (k_cur == KW'(D - 1))};
  end

  always_ff @(posedge clk) if (din_dv) fifo_q[idx] <= fifo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q <= '0;
      primed_q <= 1'b0;
      bf_q <= '0;
      n_q <= '0;
      byp_q <= 1'b0;
      tag_q <= '0;
    end else begin
      k_q <= k_d;
      primed_q <= primed_d;
      bf_q <= bf_d;
      n_q <= n_d;
      byp_q <= byp_d;
      tag_q <= tag_d;
    end
  end

  prach_diffft2_twiddler #(.NUM_FFT_LENGTH(NUM_FFT_LENGTH)) u_tw (
    .clk(clk),
    .rst_n(rst_n),
    .din(bf_q),
    .n(n_q),
    .byp(byp_q),
    .tag_in(tag_q),
    .dout(tw_o),
    .tag_out(tag_o)
  );

  assign dout_dr = tw_o.re;
  assign dout_di = tw_o.im;
  assign {dout_dv, sync_out, sync_ahead_out} = tag_o;
endmodule

// File: tb/tb_prach_diffft2.sv
// tb_prach_diffft2: directed vectors for the DIF stage at NUM_FFT_LENGTH=6 (D=32).
module tb_prach_diffft2;
  localparam int N = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [17:0] din_dr = '0, din_di = '0;
  logic din_dv = 1'b0, sync_in = 1'b0, sync_ahead_in = 1'b0;
  logic signed [17:0] dout_dr, dout_di;
  logic dout_dv, sync_out, sync_ahead_out;
  int checks = 0, errors = 0;
  int xr [N];
  int xi [N];
  int q_re[$], q_im[$], q_sy[$], q_sa[$];
  int e_re[$], e_im[$], e_sy[$], e_sa[$];
  logic [3:0] hist = '0;
  bit lat_en = 1'b0;

  prach_diffft2 #(.NUM_FFT_LENGTH(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .din_dr(din_dr),
    .din_di(din_di),
    .din_dv(din_dv),
    .sync_in(sync_in),
    .sync_ahead_in(sync_ahead_in),
    .dout_dr(dout_dr),
    .dout_di(dout_di),
    .dout_dv(dout_dv),
    .sync_out(sync_out),
    .sync_ahead_out(sync_ahead_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // output capture; hist[3] is din_dv four cycles back
  always @(negedge clk) begin
    if (lat_en && dout_dv) chk("latency", int'(hist[3]), 1);
    hist <= {hist[2:0], din_dv};
    if (dout_dv) begin
      q_re.push_back(int'(dout_dr));
      q_im.push_back(int'(dout_di));
      q_sy.push_back(int'(sync_out));
      q_sa.push_back(int'(sync_ahead_out));
    end
  end

  task automatic clear_q();
    q_re.delete(); q_im.delete(); q_sy.delete(); q_sa.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; din_dv = 1'b0; sync_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_q();
  endtask

  task automatic drive(input int re, input int im, input bit s, input int gap);
    din_dr = 18'(re); din_di = 18'(im); sync_in = s; din_dv = 1'b1;
    @(posedge clk); #1;
    din_dv = 1'b0; sync_in = 1'b0;
    repeat (gap - 1) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int cnt, input int gap);
    for (int i = 0; i < cnt; i++) drive(xr[i], xi[i], i == 0, gap);
  endtask

  task automatic fill(input int re, input int im);
    for (int i = 0; i < N; i++) begin xr[i] = re; xi[i] = im; end
  endtask

  task automatic exp_out(input int re, input int im, input int sy, input int sa);
    e_re.push_back(re); e_im.push_back(im); e_sy.push_back(sy); e_sa.push_back(sa);
  endtask

  // first frame's sums, its differences, then the second frame's sums
  task automatic exp_3(input int are, input int aim, input int bre, input int bim,
                       input int cre, input int cim);
    for (int i = 0; i < 96; i++)
      exp_out(i < 32 ? are : i < 64 ? bre : cre, i < 32 ? aim : i < 64 ? bim : cim,
              int'(i == 0 || i == 64), int'(i == 63));
  endtask

  task automatic exp_impulse();
    for (int i = 0; i < 96; i++)
      exp_out((i == 0 || i == 32) ? 16384 : 0, 0, int'(i == 0 || i == 64), int'(i == 63));
  endtask

  task automatic compare(input string tag);
    repeat (8) @(posedge clk);
    #1 chk($sformatf("%s.count", tag), q_re.size(), e_re.size());
    for (int i = 0; i < e_re.size() && i < q_re.size(); i++) begin
      chk($sformatf("%s.re[%0d]", tag, i), q_re[i], e_re[i]);
      chk($sformatf("%s.im[%0d]", tag, i), q_im[i], e_im[i]);
      chk($sformatf("%s.sync[%0d]", tag, i), q_sy[i], e_sy[i]);
      chk($sformatf("%s.ahead[%0d]", tag, i), q_sa[i], e_sa[i]);
    end
    e_re.delete(); e_im.delete(); e_sy.delete(); e_sa.delete();
  endtask

  task automatic twiddle_case(input int gap, input string tag);
    do_reset();
    fill(0, 0);
    xr[1] = 65536; xr[33] = -65536; xr[16] = 32768;
    send(N, gap);
    fill(0, 0);
    send(N, gap);
    exp_3(0, 0, 0, 0, 0, 0);
    e_re[16] = 16384;
    e_re[33] = 65220; e_im[33] = -6424;
    e_im[48] = -16384;
    compare(tag);
  endtask

  initial begin
    #12;
    chk("rst.dv", int'(dout_dv), 0);
    chk("rst.dr", int'(dout_dr), 0);
    chk("rst.di", int'(dout_di), 0);
    chk("rst.sync", int'(sync_out), 0);
    chk("rst.ahead", int'(sync_ahead_out), 0);
    do_reset();
    fill(0, 0); xr[0] = 32768;
    send(N, 1);
    fill(0, 0);
    send(N, 1);
    exp_impulse();
    compare("impulse");
    do_reset();
    fill(65536, 0);
    send(N, 1);
    send(N, 1);
    exp_3(65536, 0, 0, 0, 65536, 0);
    compare("dc");
    do_reset();
    fill(131071, -131072);
    send(N, 1);
    fill(-131072, 131071);
    send(N, 1);
    exp_3(131071, -131072, 0, 0, -131072, 131071);
    compare("fullscale");
    twiddle_case(1, "twiddle");
    lat_en = 1'b1;
    twiddle_case(3, "gapped");
    lat_en = 1'b0;
    do_reset();
    fill(4096, 0);
    send(N, 1);
    send(17, 1);
    fill(0, 0); xr[0] = 32768;
    send(N, 1);
    fill(0, 0);
    send(N, 1);
    for (int i = 0; i < 32; i++) exp_out(4096, 0, int'(i == 0), 0);
    for (int i = 0; i < 17; i++) exp_out(0, 0, 0, 0);
    exp_impulse();
    compare("resync");
    do_reset();
    fill(0, 0);
    for (int i = 0; i < 32; i++) xr[i] = 4096;
    send(N, 1);
    send(10, 1);
    chk("prerst.dv", int'(dout_dv), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.dv", int'(dout_dv), 0);
    chk("arst.dr", int'(dout_dr), 0);
    chk("arst.di", int'(dout_di), 0);
    chk("arst.sync", int'(sync_out), 0);
    chk("arst.ahead", int'(sync_ahead_out), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_q();
    fill(0, 0); xr[0] = 32768;
    send(N, 1);
    fill(0, 0);
    send(N, 1);
    exp_impulse();
    compare("after_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
